// File: rtl/iob_timer_sampler.sv
// Native-bus initiator: on each capture pulse, snapshots a timer peripheral
// (SAMPLE=1, SAMPLE=0, read LOW, read HIGH) and presents the 64-bit value.
module iob_timer_sampler #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int ENABLE_ADDR = 1,
  parameter int SAMPLE_ADDR = 2,
  parameter int LOW_ADDR    = 3,
  parameter int HIGH_ADDR   = 4,
  parameter int AUTO_ENABLE = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready,
  output logic [2*DATA_W-1:0]   timestamp,
  output logic                  ts_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  error
);

  localparam int SW = DATA_W / 8;

  localparam logic [2:0] S_EN   = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_SET  = 3'd2;
  localparam logic [2:0] S_CLR  = 3'd3;
  localparam logic [2:0] S_RDL  = 3'd4;
  localparam logic [2:0] S_RDH  = 3'd5;
  localparam logic [2:0] S_RST  = (AUTO_ENABLE != 0) ? S_EN : S_IDLE;

  logic [2:0]          state_q, state_d;
  logic                gap_q, gap_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   low_q, low_d;
  logic [2*DATA_W-1:0] ts_q, ts_d;
  logic                ts_valid_q, ts_valid_d;
  logic                overrun_q, overrun_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_address_q, m_address_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [SW-1:0]       m_wstrb_q, m_wstrb_d;

  logic done, waiting, expired;

  // Completion and waiting are qualified by the registered valid, so the silent
  // first cycle after reset (EN access with m_valid still low) is harmless.
  assign done    = m_valid_q && m_ready;
  assign waiting = m_valid_q && !m_ready;
  assign expired = (TIMEOUT != 0) && (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    low_d      = low_q;
    ts_d       = ts_q;
    ts_valid_d = 1'b0;
    overrun_d  = 1'b0;
    error_d    = 1'b0;

    if (state_q == S_IDLE) begin
      if (capture || pend_q) begin
        state_d = S_SET;
        gap_d   = 1'b0;
        cnt_d   = '0;
        // A fresh capture arriving while a pending one is consumed re-arms pend.
        pend_d  = capture && pend_q;
      end
    end else begin
      if (capture) begin
        if (pend_q) overrun_d = 1'b1;
        else        pend_d    = 1'b1;
      end
      if (gap_q) begin
        gap_d = 1'b0;
        cnt_d = '0;
        case (state_q)
          S_SET:   state_d = S_CLR;
          S_CLR:   state_d = S_RDL;
          S_RDL:   state_d = S_RDH;
          default: state_d = S_IDLE;
        endcase
      end else if (done) begin
        if (state_q == S_RDL) low_d = m_rdata;
        if (state_q == S_RDH) begin
          ts_d       = {m_rdata, low_q};
          ts_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          gap_d = 1'b1;
        end
      end else if (waiting) begin
        if (expired) begin
          error_d = 1'b1;
          state_d = S_IDLE;
          gap_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    busy_d      = (state_d != S_IDLE);
    m_valid_d   = busy_d && !gap_d;
    m_address_d = '0;
    m_wdata_d   = '0;
    m_wstrb_d   = '0;
    if (m_valid_d) begin
      case (state_d)
        S_EN: begin
          m_address_d = ADDR_W'(ENABLE_ADDR);
          m_wdata_d   = DATA_W'(1);
          m_wstrb_d   = '1;
        end
        S_SET: begin
          m_address_d = ADDR_W'(SAMPLE_ADDR);
          m_wdata_d   = DATA_W'(1);
          m_wstrb_d   = '1;
        end
        S_CLR: begin
          m_address_d = ADDR_W'(SAMPLE_ADDR);
          m_wstrb_d   = '1;
        end
        S_RDL:   m_address_d = ADDR_W'(LOW_ADDR);
        default: m_address_d = ADDR_W'(HIGH_ADDR);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RST;
      gap_q       <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      low_q       <= '0;
      ts_q        <= '0;
      ts_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      low_q       <= low_d;
      ts_q        <= ts_d;
      ts_valid_q  <= ts_valid_d;
      overrun_q   <= overrun_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      m_valid_q   <= m_valid_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_address = m_address_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign timestamp = ts_q;
  assign ts_valid  = ts_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign error     = error_q;

endmodule

// File: tb/tb_iob_timer_sampler.sv
// Bench for iob_timer_sampler: timer/responder model with registered, zero-wait
// and never-ready modes; expected bus order and timestamps come from the model.
module tb_iob_timer_sampler;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          capture;
  logic          m_valid;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic [63:0]   timestamp;
  logic          ts_valid, busy, overrun, error;

  iob_timer_sampler #(
    .ADDR_W(AW), .DATA_W(DW), .ENABLE_ADDR(1), .SAMPLE_ADDR(2), .LOW_ADDR(3),
    .HIGH_ADDR(4), .AUTO_ENABLE(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .capture(capture),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .timestamp(timestamp), .ts_valid(ts_valid), .busy(busy),
    .overrun(overrun), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer peripheral model: SAMPLE=1 snapshots the free-running value.
  int          mode = 0;  // 0: registered ready, 1: zero-wait, 2: never ready
  logic        rdy_q;
  logic [63:0] timer_val = 64'd0;
  logic [63:0] snap = 64'd0;

  assign m_ready = (mode == 1) ? m_valid : ((mode == 0) ? rdy_q : 1'b0);
  assign m_rdata = (m_address == 4'd3) ? snap[31:0] :
                   (m_address == 4'd4) ? snap[63:32] : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else begin
      rdy_q <= (mode == 0) && m_valid && !rdy_q;
      if (m_valid && m_ready && m_wstrb != 4'h0 && m_address == 4'd2 && m_wdata == 32'd1)
        snap <= timer_val;
    end
  end

  // Bus/event monitor, sampled mid-cycle.
  logic [31:0] q_addr[$], q_wdata[$], q_wstrb[$];
  int          q_tscyc[$];
  int          ts_count = 0, ov_count = 0, err_count = 0, gap_viol = 0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      q_addr.push_back(32'(m_address));
      q_wdata.push_back(m_wdata);
      q_wstrb.push_back(32'(m_wstrb));
    end
    if (done_prev && m_valid) gap_viol <= gap_viol + 1;
    done_prev <= m_valid && m_ready;
    if (ts_valid) begin
      ts_count <= ts_count + 1;
      q_tscyc.push_back(cyc);
    end
    if (overrun) ov_count  <= ov_count + 1;
    if (error)   err_count <= err_count + 1;
  end

  // Reference sequence of one capture: SET, CLR, read LOW, read HIGH.
  int ea[4] = '{2, 2, 3, 4};
  int ew[4] = '{1, 0, 0, 0};
  int es[4] = '{15, 15, 0, 0};

  logic [63:0] exp_ts = 64'd0;
  int          cap_cyc;

  task automatic clear_log();
    q_addr.delete(); q_wdata.delete(); q_wstrb.delete(); q_tscyc.delete();
  endtask

  task automatic pulse_capture();
    @(negedge clk);
    capture = 1'b1;
    cap_cyc = cyc;
    @(negedge clk);
    capture = 1'b0;
  endtask

  task automatic run_seq(input logic [63:0] val, input int exp_lat, input string name);
    int base;
    timer_val = val;
    clear_log();
    base = ts_count;
    pulse_capture();
    for (int i = 0; i < 40 && ts_count == base; i++) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (ts_count !== base + 1) begin
      n_fail++; $display("FAIL %s_ts_count: got %0d expected %0d", name, ts_count - base, 1);
    end
    n_tests++;
    if (q_addr.size() !== 4) begin
      n_fail++; $display("FAIL %s_bus_len: got %0d expected 4", name, q_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (q_addr[k] !== 32'(ea[k]) || q_wdata[k] !== 32'(ew[k]) || q_wstrb[k] !== 32'(es[k])) begin
          n_fail++;
          $display("FAIL %s_bus%0d: got a=%0h d=%0h s=%0h expected a=%0h d=%0h s=%0h",
                   name, k, q_addr[k], q_wdata[k], q_wstrb[k], ea[k], ew[k], es[k]);
        end
      end
    end
    exp_ts = val;
    n_tests++;
    if (timestamp !== exp_ts) begin
      n_fail++; $display("FAIL %s_timestamp: got %h expected %h", name, timestamp, exp_ts);
    end
    n_tests++;
    if (q_tscyc.size() < 1 || q_tscyc[0] - cap_cyc !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected %0d", name,
               (q_tscyc.size() < 1) ? -1 : q_tscyc[0] - cap_cyc, exp_lat);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_after: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; capture = 1'b0; mode = 0;
    clear_log();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({m_valid, m_address, m_wdata, m_wstrb, timestamp, ts_valid, busy, overrun, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b a=%0h d=%0h s=%0h ts=%h tv=%b b=%b o=%b e=%b expected all 0",
               m_valid, m_address, m_wdata, m_wstrb, timestamp, ts_valid, busy, overrun, error);
    end
    rst = 1'b0;
    for (int i = 0; i < 20 && q_addr.size() == 0; i++) @(posedge clk);
    repeat (4) @(negedge clk);
    n_tests++;
    if (q_addr.size() !== 1) begin
      n_fail++; $display("FAIL reset_en_count: got %0d expected 1", q_addr.size());
    end else begin
      n_tests++;
      if (q_addr[0] !== 32'd1 || q_wdata[0] !== 32'd1 || q_wstrb[0] !== 32'hF) begin
        n_fail++;
        $display("FAIL reset_en_write: got a=%0h d=%0h s=%0h expected a=1 d=1 s=f",
                 q_addr[0], q_wdata[0], q_wstrb[0]);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", busy, m_valid);
    end
  endtask

  task automatic test_capture();
    mode = 0;
    run_seq(64'h0000_0001_8000_0002, 12, "cap_fixed");
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      run_seq({$urandom, $urandom}, 12, "cap_rand");
    end
  endtask

  task automatic test_back_to_back();
    int base_ts, base_ov;
    logic [63:0] val;
    mode = 0;
    val = {$urandom, $urandom};
    timer_val = val;
    clear_log();
    base_ts = ts_count; base_ov = ov_count;
    @(negedge clk); capture = 1'b1; cap_cyc = cyc;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); capture = 1'b0;
    for (int i = 0; i < 60 && ts_count < base_ts + 2; i++) @(posedge clk);
    repeat (15) @(negedge clk);
    n_tests++;
    if (ts_count - base_ts !== 2) begin
      n_fail++; $display("FAIL b2b_seq_count: got %0d expected 2", ts_count - base_ts);
    end
    n_tests++;
    if (ov_count - base_ov !== 1) begin
      n_fail++; $display("FAIL b2b_overrun: got %0d expected 1", ov_count - base_ov);
    end
    n_tests++;
    if (q_addr.size() !== 8) begin
      n_fail++; $display("FAIL b2b_bus_len: got %0d expected 8", q_addr.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (q_addr[k] !== 32'(ea[k%4]) || q_wdata[k] !== 32'(ew[k%4])) begin
          n_fail++;
          $display("FAIL b2b_bus%0d: got a=%0h d=%0h expected a=%0h d=%0h",
                   k, q_addr[k], q_wdata[k], ea[k%4], ew[k%4]);
        end
      end
    end
    n_tests++;
    if (q_tscyc.size() !== 2 || q_tscyc[0] - cap_cyc !== 12 || q_tscyc[1] - q_tscyc[0] !== 12) begin
      n_fail++;
      $display("FAIL b2b_spacing: got n=%0d first=%0d gap=%0d expected n=2 first=12 gap=12", q_tscyc.size(),
               (q_tscyc.size() > 0) ? q_tscyc[0] - cap_cyc : -1,
               (q_tscyc.size() > 1) ? q_tscyc[1] - q_tscyc[0] : -1);
    end
    exp_ts = val;
    n_tests++;
    if (timestamp !== exp_ts) begin
      n_fail++; $display("FAIL b2b_timestamp: got %h expected %h", timestamp, exp_ts);
    end
  endtask

  task automatic test_timeout();
    int hi, base_err;
    mode = 2;
    clear_log();
    base_err = err_count;
    timer_val = {$urandom, $urandom};
    pulse_capture();
    hi = (m_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid) hi++;
      else if (hi > 0) break;
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (hi !== TO) begin
      n_fail++; $display("FAIL timeout_valid_len: got %0d expected %0d", hi, TO);
    end
    n_tests++;
    if (err_count - base_err !== 1) begin
      n_fail++; $display("FAIL timeout_error: got %0d expected 1", err_count - base_err);
    end
    n_tests++;
    if (timestamp !== exp_ts || busy !== 1'b0 || q_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL timeout_state: got ts=%h busy=%b txns=%0d expected ts=%h busy=0 txns=0",
               timestamp, busy, q_addr.size(), exp_ts);
    end
    mode = 0;
    run_seq({$urandom, $urandom}, 12, "after_timeout");
  endtask

  task automatic test_reset_mid();
    mode = 0;
    clear_log();
    timer_val = {$urandom, $urandom};
    pulse_capture();
    for (int i = 0; i < 40 && !(m_valid && m_address == 4'd3); i++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid: got %b expected 0", m_valid);
    end
    n_tests++;
    if ({m_address, m_wdata, m_wstrb, timestamp, ts_valid, busy, overrun, error} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got a=%0h d=%0h s=%0h ts=%h tv=%b b=%b o=%b e=%b expected all 0",
               m_address, m_wdata, m_wstrb, timestamp, ts_valid, busy, overrun, error);
    end
    exp_ts = 64'd0;
    repeat (3) @(negedge clk);
    clear_log();
    rst = 1'b0;
    for (int i = 0; i < 20 && q_addr.size() == 0; i++) @(posedge clk);
    repeat (4) @(negedge clk);
    n_tests++;
    if (q_addr.size() !== 1 || q_addr[0] !== 32'd1 || q_wdata[0] !== 32'd1 || q_wstrb[0] !== 32'hF) begin
      n_fail++;
      $display("FAIL midrst_en_reissue: got n=%0d a=%0h expected n=1 a=1 d=1 s=f", q_addr.size(),
               (q_addr.size() > 0) ? q_addr[0] : 32'hFFFF_FFFF);
    end
    n_tests++;
    if (timestamp !== exp_ts || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle: got ts=%h busy=%b expected %h 0", timestamp, busy, exp_ts);
    end
  endtask

  task automatic test_zero_wait();
    int base_gap;
    mode = 1;
    base_gap = gap_viol;
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_seq({$urandom, $urandom}, 8, "zero_wait");
    end
    n_tests++;
    if (gap_viol !== base_gap) begin
      n_fail++; $display("FAIL zero_wait_gap: got %0d violations expected 0", gap_viol - base_gap);
    end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_zero_wait();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
